dmux_arbiter: RTL
=================

# dmux_arbiter

Round-robin write arbiter that shares one DMux8Way16 distribution path between N_REQ requesters. Each requester presents 16-bit words tagged with a 3-bit destination; the arbiter grants one requester at a time, holds the grant for a multi-word burst, and drives the demux data/select inputs plus a one-hot load strobe toward the eight destination registers. It sits between the requesting units and the 8-way register bank fed by the demux.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, data word width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester beat valid
- req_ready  out  N_REQ  per-requester beat accepted this cycle (combinational)
- req_data  in  N_REQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
- req_dest  in  N_REQ*3  requester i destination at bits [i*3 +: 3]
- req_last  in  N_REQ  beat is last of burst
- stall  in  1  destination bank busy; no beat accepted while high
- dmux_in  out  WIDTH  registered word to demux `in`
- dmux_sel  out  3  registered destination to demux `sel`
- load  out  8  registered one-hot write strobe, bit = dmux_sel
- grant  out  N_REQ  registered one-hot current owner (0 in IDLE)
- busy  out  1  high in LOCKED

## Operation
- Beat accepted when req_valid[i] && req_ready[i]; at most one ready bit high per cycle.
- States: IDLE, LOCKED. Reset: IDLE, rr pointer = 0, all outputs 0.
- IDLE, stall=0, any valid: winner = first valid requester at or after pointer (wrapping modulo N_REQ); ready[winner]=1, beat accepted. If req_last on that beat: stay IDLE, pointer = winner+1 mod N_REQ. Else: LOCKED, owner = winner, grant = one-hot(winner).
- LOCKED: only ready[owner] may be high (when req_valid[owner] && !stall). Other requesters' valid ignored. Owner valid low: idle cycle, grant held. Accepted beat with req_last: IDLE, pointer = owner+1, grant cleared next cycle.
- stall=1: all ready low, state/pointer unchanged, load = 0 next cycle.
- Each beat may carry a different req_dest; dmux_sel follows per beat.
- Output register: on accepted beat, dmux_in <= data, dmux_sel <= dest, load <= 1<<dest. No accepted beat: load <= 0; dmux_in, dmux_sel hold last value.
- Reset mid-burst: burst aborted, no load issued, arbitration restarts at requester 0.

## Timing
- Latency: beat accepted at edge t -> load/dmux_in/dmux_sel valid for the cycle after t, load one cycle wide.
- Throughput: 1 beat/cycle, including bursts back-to-back from different requesters (last beat at t, next owner's first beat at t+1, no bubble).
- req_ready depends combinationally on req_valid, stall, state, pointer; no combinational path from req_data to any output.
- Single-beat bursts never enter LOCKED.

## Structure
- Shared header dmux_arb_defs.vh (`ifndef`-guarded): state encodings ST_IDLE/ST_LOCKED, DEST_BITS = 3, N_DEST = 8.
- Sub-module rr_pick: inputs valid[N_REQ], pointer; outputs one-hot winner and its index; purely combinational.
- Top instantiates rr_pick, the 2-state FSM, pointer/owner registers, output register; drives an external DMux8Way16 via dmux_in/dmux_sel.

## Test plan
- Reset: rst_n low mid-run -> all outputs 0 immediately; after release, req 2 and req 0 valid single beats -> req 0 served first.
- Round-robin: all four valid, single-beat, dests 1,2,3,4 -> grants 0,1,2,3 in consecutive cycles, load = 0x02,0x04,0x08,0x10 one cycle later each.
- Burst lock: req 1 burst of 3 (0xAAAA->5, 0xBBBB->6, 0xCCCC->5, last), req 0 valid throughout -> req 0 ready low for all 3 beats, busy high 2 cycles, req 0 served next cycle.
- Owner gap: req 3 burst drops valid 2 cycles mid-burst while req 1 valid -> grant stays 0b1000, load 0 during gap, req 1 blocked until req 3 last.
- Stall: stall high 3 cycles during burst -> no ready, load 0, pointer/owner unchanged; burst resumes on stall low.
- Wrap: N_REQ=4, pointer=3, req 0 and req 3 valid -> req 3 first, then req 0.

Source files
------------

// File: rtl/dmux_arbiter_pkg.sv
// Shared definitions for the DMux8Way16 write arbiter: FSM encoding,
// destination geometry and the destination-to-strobe helper.
package dmux_arbiter_pkg;

    localparam int unsigned DEST_BITS = 3;
    localparam int unsigned N_DEST    = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    typedef logic [DEST_BITS-1:0] dest_t;
    typedef logic [N_DEST-1:0]    load_t;

    // One-hot register-bank write strobe for a destination index
    function automatic load_t dest_to_load(input dest_t d);
        return load_t'(1) << d;
    endfunction

endpackage

// File: rtl/dmux_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after the pointer,
// wrapping modulo N_REQ. Purely combinational.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PTR_W-1:0] pointer,
    output logic [N_REQ-1:0] winner_c,
    output logic [PTR_W-1:0] winner_idx_c,
    output logic             any_valid_c
);

    logic [PTR_W-1:0] cand;

    // Scan from the pointer upward, keep the first hit
    always_comb begin
        winner_c     = '0;
        winner_idx_c = '0;
        any_valid_c  = 1'b0;
        cand         = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = PTR_W'((32'(pointer) + off) % N_REQ);
            if (!any_valid_c && valid[cand]) begin
                any_valid_c  = 1'b1;
                winner_idx_c = cand;
                winner_c     = N_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/dmux_arbiter.sv
// Round-robin burst arbiter feeding one DMux8Way16 path: grants one
// requester at a time, holds the grant across a burst and registers the
// demux word/select plus a one-hot load strobe.
module dmux_arbiter
    import dmux_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    input  logic [N_REQ*DEST_BITS-1:0] req_dest,
    input  logic [N_REQ-1:0]           req_last,
    input  logic                       stall,
    output logic [WIDTH-1:0]           dmux_in,
    output logic [DEST_BITS-1:0]       dmux_sel,
    output logic [N_DEST-1:0]          load,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] owner_q;

    logic [N_REQ-1:0] pick_oh_c;
    logic [PTR_W-1:0] pick_idx_c;
    logic             pick_any_c;

    logic [N_REQ-1:0] ready_c;
    logic             accept_c;
    logic [PTR_W-1:0] acc_idx_c;
    logic [WIDTH-1:0] acc_data_c;
    dest_t            acc_dest_c;
    logic             acc_last_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return PTR_W'((32'(p) + 32'd1) % N_REQ);
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .valid        (req_valid),
        .pointer      (ptr_q),
        .winner_c     (pick_oh_c),
        .winner_idx_c (pick_idx_c),
        .any_valid_c  (pick_any_c)
    );

    // Beat acceptance: round-robin winner when idle, owner only when locked
    always_comb begin
        ready_c   = '0;
        accept_c  = 1'b0;
        acc_idx_c = '0;
        if (rst_n && !stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any_c) begin
                        ready_c   = pick_oh_c;
                        accept_c  = 1'b1;
                        acc_idx_c = pick_idx_c;
                    end
                end
                ST_LOCKED: begin
                    if (req_valid[owner_q]) begin
                        ready_c   = N_REQ'(1) << owner_q;
                        accept_c  = 1'b1;
                        acc_idx_c = owner_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload of the accepted lane; feeds registers only
    always_comb begin
        acc_data_c = '0;
        acc_dest_c = '0;
        acc_last_c = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ready_c[i]) begin
                acc_data_c = req_data[i*WIDTH +: WIDTH];
                acc_dest_c = req_dest[i*DEST_BITS +: DEST_BITS];
                acc_last_c = req_last[i];
            end
        end
    end

    assign req_ready = ready_c;
    assign busy      = (state_q == ST_LOCKED);

    // FSM, round-robin pointer, owner and demux output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            grant    <= '0;
            dmux_in  <= '0;
            dmux_sel <= '0;
            load     <= '0;
        end else begin
            load <= '0;
            if (accept_c) begin
                dmux_in  <= acc_data_c;
                dmux_sel <= acc_dest_c;
                load     <= dest_to_load(acc_dest_c);
                if (acc_last_c) begin
                    state_q <= ST_IDLE;
                    ptr_q   <= ptr_inc(acc_idx_c);
                    grant   <= '0;
                end else begin
                    state_q <= ST_LOCKED;
                    owner_q <= acc_idx_c;
                    grant   <= N_REQ'(1) << acc_idx_c;
                end
            end
        end
    end

endmodule
